// File: rtl/noc_pkt_pkg.sv
// Packet layout shared by the adder (packer) and the result writer (unpacker).
// Fields from MSB: {dst, src, type, payload}; payload is two's complement.
package noc_pkt_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 20;
    localparam int PAYLOAD_W = DATA_W - 2 * ADDR_W - 1;

    localparam int DST_LSB  = DATA_W - ADDR_W;
    localparam int SRC_LSB  = DST_LSB - ADDR_W;
    localparam int TYPE_BIT = SRC_LSB - 1;

    typedef struct packed {
        logic [ADDR_W-1:0]    dst;
        logic [ADDR_W-1:0]    src;
        logic                 typ;
        logic [PAYLOAD_W-1:0] payload;
    } noc_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } wr_state_t;

    function automatic logic [ADDR_W-1:0] get_dst(input logic [DATA_W-1:0] d);
        return d[DST_LSB +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] get_src(input logic [DATA_W-1:0] d);
        return d[SRC_LSB +: ADDR_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] get_payload(input logic [DATA_W-1:0] d);
        return d[PAYLOAD_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] pack(input logic [ADDR_W-1:0]    dst,
                                               input logic [ADDR_W-1:0]    src,
                                               input logic                 typ,
                                               input logic [PAYLOAD_W-1:0] payload);
        noc_pkt_t p;
        p.dst     = dst;
        p.src     = src;
        p.typ     = typ;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/psum_result_writer_if.sv
// Start / packet / done handshakes plus the output-memory write port of the result writer.
// Every valid/ready pair: a transfer happens on a cycle with valid & ready high; once valid
// rises it is held with stable data until ready is seen, and ready never depends on valid.
interface psum_result_writer_if #(
    parameter int MEM_AW = 4
);
    logic                                  start_valid;
    logic                                  start_ready;
    logic                                  pkt_valid;
    logic [noc_pkt_pkg::DATA_W-1:0]        pkt_data;
    logic                                  pkt_ready;
    logic                                  mem_we;
    logic [MEM_AW-1:0]                     mem_addr;
    logic [noc_pkt_pkg::PAYLOAD_W-1:0]     mem_wdata;
    logic                                  done_valid;
    logic                                  done_ready;
    logic                                  err_misroute;
    noc_pkt_pkg::wr_state_t                dbg_state;
    logic [MEM_AW:0]                       dbg_count;

    modport slave (
        input  start_valid, pkt_valid, pkt_data, done_ready,
        output start_ready, pkt_ready, mem_we, mem_addr, mem_wdata,
               done_valid, err_misroute, dbg_state, dbg_count
    );

    modport master (
        output start_valid, pkt_valid, pkt_data, done_ready,
        input  start_ready, pkt_ready, mem_we, mem_addr, mem_wdata,
               done_valid, err_misroute, dbg_state, dbg_count
    );
endinterface

// File: rtl/psum_result_writer_pkt_unpack.sv
// Combinational field extraction for an incoming result packet.
// With RESULT_RELU_EN defined, negative payloads are clamped to zero.
module pkt_unpack
    import noc_pkt_pkg::*;
(
    input  logic [DATA_W-1:0]    pkt_data,
    output logic [ADDR_W-1:0]    dst,
    output logic [PAYLOAD_W-1:0] payload
);
    logic [PAYLOAD_W-1:0] raw;
    logic                 unused_fields;

    assign dst = get_dst(pkt_data);
    assign raw = get_payload(pkt_data);
    // src and type travel with the packet but play no part in the write.
    assign unused_fields = ^{get_src(pkt_data), pkt_data[TYPE_BIT]};

`ifdef RESULT_RELU_EN
    assign payload = raw[PAYLOAD_W-1] ? '0 : raw;
`else
    assign payload = raw;
`endif
endmodule

// File: rtl/psum_result_writer.sv
// Memory-side endpoint: writes TOT_NUM addressed results sequentially, then returns a done token.
// Optional build macro RESULT_RELU_EN clamps negative results to zero (see pkt_unpack).
module psum_result_writer
    import noc_pkt_pkg::*;
#(
    parameter int                TOT_NUM  = 9,
    parameter int                MEM_AW   = 4,
    parameter logic [ADDR_W-1:0] MY_INDEX = 5'd0
)(
    input  logic                  clk,
    input  logic                  rst,
    psum_result_writer_if.slave   bus
);
    localparam logic [MEM_AW:0] TOT_C = (MEM_AW + 1)'(TOT_NUM);

    wr_state_t             state, state_nxt;
    logic [MEM_AW:0]       count;
    logic                  mem_we_q;
    logic [MEM_AW-1:0]     mem_addr_q;
    logic [PAYLOAD_W-1:0]  mem_wdata_q;
    logic                  err_q;

    logic                  start_ready_c, pkt_ready_c, done_valid_c;
    logic                  start_fire, pkt_fire, done_fire, pkt_hit;
    logic [ADDR_W-1:0]     pkt_dst;
    logic [PAYLOAD_W-1:0]  pkt_payload;

    pkt_unpack u_unpack (
        .pkt_data (bus.pkt_data),
        .dst      (pkt_dst),
        .payload  (pkt_payload)
    );

    always_comb begin
        state_nxt     = state;
        start_ready_c = 1'b0;
        pkt_ready_c   = 1'b0;
        done_valid_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready_c = 1'b1;
                if (bus.start_valid) state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                // Ready drops as soon as the last write is issued, one edge before DONE.
                pkt_ready_c = (count < TOT_C);
                if (count == TOT_C) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_valid_c = 1'b1;
                if (bus.done_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign start_fire = bus.start_valid & start_ready_c;
    assign pkt_fire   = bus.pkt_valid & pkt_ready_c;
    assign done_fire  = done_valid_c & bus.done_ready;
    assign pkt_hit    = (pkt_dst == MY_INDEX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_we_q <= 1'b0;
            if (start_fire) begin
                count <= '0;
                err_q <= 1'b0;
            end
            if (pkt_fire) begin
                if (pkt_hit) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= count[MEM_AW-1:0];
                    mem_wdata_q <= pkt_payload;
                    count       <= count + 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (done_fire) count <= '0;
        end
    end

    assign bus.start_ready  = start_ready_c;
    assign bus.pkt_ready    = pkt_ready_c;
    assign bus.done_valid   = done_valid_c;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.err_misroute = err_q;
    assign bus.dbg_state    = state;
    assign bus.dbg_count    = count;
endmodule

// File: tb/tb_psum_result_writer.sv
// Bench for psum_result_writer: vector table, hand sequences for the multi-cycle corners,
// and randomized jobs scored against an address/data queue model.
module tb_psum_result_writer;
    import noc_pkt_pkg::*;

    localparam int TOT     = 9;
    localparam int MAW     = 4;
    localparam int TIMEOUT = 200;

`ifdef RESULT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    psum_result_writer_if #(.MEM_AW(MAW)) bus ();

    psum_result_writer #(
        .TOT_NUM  (TOT),
        .MEM_AW   (MAW),
        .MY_INDEX (5'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [MAW+PAYLOAD_W-1:0] exp_q[$];
    logic [MAW+PAYLOAD_W-1:0] mon_e;
    int   model_count;
    logic model_err;

    typedef struct {
        logic [ADDR_W-1:0]    dst;
        logic [PAYLOAD_W-1:0] pl;
        logic                 exp_we;
        logic [PAYLOAD_W-1:0] exp_data;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what the memory should hold for a given payload.
    function automatic logic [PAYLOAD_W-1:0] ref_data(input logic [PAYLOAD_W-1:0] p);
        if (RELU && $signed(p) < 0) return '0;
        return p;
    endfunction

    // Scoreboard: every write strobe must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0h required=no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        int n = 0;
        bus.start_valid = 1'b1;
        while (bus.start_ready !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("FAIL start_timeout actual=no start_ready required=start_ready");
        end
        tick();
        bus.start_valid = 1'b0;
        model_count = 0;
        model_err   = 1'b0;
    endtask

    task automatic send_pkt(input logic [ADDR_W-1:0] dst, input logic [PAYLOAD_W-1:0] pl,
                            input bit keep);
        int n = 0;
        bus.pkt_valid = 1'b1;
        if (!keep)
            bus.pkt_data = pack(dst, ADDR_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), pl);
        while (bus.pkt_ready !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("FAIL pkt_timeout actual=no pkt_ready required=pkt_ready dst=%0d", dst);
            bus.pkt_valid = 1'b0;
            return;
        end
        tick();
        bus.pkt_valid = 1'b0;
        if (dst == 5'd0) begin
            exp_q.push_back({MAW'(model_count), ref_data(pl)});
            model_count++;
        end else begin
            model_err = 1'b1;
        end
    endtask

    task automatic finish_job(input int hold);
        int n = 0;
        while (bus.done_valid !== 1'b1 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("done_valid_rise", bus.done_valid, 1);
        check("err_misroute", bus.err_misroute, model_err);
        check("writes_drained", exp_q.size(), 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("done_hold", bus.done_valid, 1);
            check("pkt_ready_in_done", bus.pkt_ready, 0);
        end
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        check("idle_start_ready", bus.start_ready, 1);
        check("idle_state", bus.dbg_state, ST_IDLE);
        check("idle_count", bus.dbg_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic [ADDR_W-1:0] d;

        bus.start_valid = 1'b0;
        bus.pkt_valid   = 1'b0;
        bus.pkt_data    = '0;
        bus.done_ready  = 1'b0;
        model_count     = 0;
        model_err       = 1'b0;

        tbl[0] = '{5'd0, 9'h001, 1'b1, 9'h001};
        tbl[1] = '{5'd0, 9'h1F0, 1'b1, RELU ? 9'h000 : 9'h1F0};
        tbl[2] = '{5'd7, 9'h055, 1'b0, 9'h000};
        tbl[3] = '{5'd0, 9'h00F, 1'b1, 9'h00F};
        tbl[4] = '{5'd0, 9'h100, 1'b1, RELU ? 9'h000 : 9'h100};
        tbl[5] = '{5'd0, 9'h0FF, 1'b1, 9'h0FF};
        tbl[6] = '{5'd0, 9'h1FF, 1'b1, RELU ? 9'h000 : 9'h1FF};
        tbl[7] = '{5'd0, 9'h0AA, 1'b1, 9'h0AA};
        tbl[8] = '{5'd0, 9'h155, 1'b1, RELU ? 9'h000 : 9'h155};
        tbl[9] = '{5'd0, 9'h07F, 1'b1, 9'h07F};

        // Reset state
        repeat (3) tick();
        check("rst_start_ready", bus.start_ready, 1);
        check("rst_pkt_ready", bus.pkt_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_done_valid", bus.done_valid, 0);
        check("rst_err", bus.err_misroute, 0);
        check("rst_count", bus.dbg_count, 0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();

        // Basic job: payloads 1..9 back to back
        do_start();
        t0 = cyc;
        for (int i = 1; i <= TOT; i++) send_pkt(5'd0, PAYLOAD_W'(i), 1'b0);
        check("b2b_cycles", cyc - t0, TOT);
        check("last_write_we", bus.mem_we, 1);
        check("last_write_addr", bus.mem_addr, TOT - 1);
        check("last_write_pkt_ready", bus.pkt_ready, 0);
        check("last_write_done_low", bus.done_valid, 0);
        tick();
        check("done_one_after_write", bus.done_valid, 1);
        check("done_no_write", bus.mem_we, 0);

        // Backpressure: a 10th packet waits through DONE and opens the next job
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = pack(5'd0, 5'd3, 1'b0, 9'h077);
        finish_job(5);
        check("held_pkt_idle_ready", bus.pkt_ready, 0);
        do_start();
        send_pkt(5'd0, 9'h077, 1'b1);
        for (int i = 1; i < TOT; i++) send_pkt(5'd0, PAYLOAD_W'($urandom_range(0, 511)), 1'b0);
        finish_job(0);

        // Table job: signed payloads and a misrouted 3rd packet
        do_start();
        foreach (tbl[i]) begin
            send_pkt(tbl[i].dst, tbl[i].pl, 1'b0);
            check("tbl_we", bus.mem_we, tbl[i].exp_we);
            if (tbl[i].exp_we) check("tbl_wdata", bus.mem_wdata, tbl[i].exp_data);
        end
        check("tbl_err_set", bus.err_misroute, 1);
        finish_job(2);

        // Reset mid-job, with a packet accepted on the reset edge
        do_start();
        for (int i = 0; i < 4; i++) send_pkt(5'd0, PAYLOAD_W'(20 + i), 1'b0);
        send_pkt(5'd9, 9'h012, 1'b0);
        check("pre_rst_err", bus.err_misroute, 1);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = pack(5'd0, 5'd1, 1'b1, 9'h1AB);
        rst = 1'b1;
        tick();
        bus.pkt_valid = 1'b0;
        rst = 1'b0;
        check("midrst_count", bus.dbg_count, 0);
        check("midrst_mem_we", bus.mem_we, 0);
        check("midrst_done", bus.done_valid, 0);
        check("midrst_start_ready", bus.start_ready, 1);
        check("midrst_err", bus.err_misroute, 0);
        tick();
        do_start();
        for (int i = 0; i < TOT; i++) send_pkt(5'd0, PAYLOAD_W'($urandom_range(0, 511)), 1'b0);
        finish_job(1);

        // Packets in IDLE are back-pressured; start during COLLECT is ignored
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = pack(5'd0, 5'd2, 1'b0, 9'h033);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_pkt_ready", bus.pkt_ready, 0);
        end
        bus.pkt_valid = 1'b0;
        do_start();
        for (int i = 0; i < 3; i++) send_pkt(5'd0, PAYLOAD_W'(i + 40), 1'b0);
        bus.start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("collect_start_ready", bus.start_ready, 0);
            check("collect_count_kept", bus.dbg_count, 3);
        end
        bus.start_valid = 1'b0;
        for (int i = 3; i < TOT; i++) send_pkt(5'd0, PAYLOAD_W'(i + 40), 1'b0);
        finish_job(0);

        // Randomized jobs with gaps and occasional misroutes
        for (int j = 0; j < 4; j++) begin
            do_start();
            while (model_count < TOT) begin
                repeat ($urandom_range(0, 2)) tick();
                d = ($urandom_range(0, 5) == 0) ? ADDR_W'($urandom_range(1, 31)) : 5'd0;
                send_pkt(d, PAYLOAD_W'($urandom_range(0, 511)), 1'b0);
            end
            finish_job($urandom_range(0, 3));
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
